// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
// Optional ILLEGAL_TRAP_EN: unlisted opcodes park the FSM in TRAP with illegal=1.
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic [2:0] imm_type,
  output logic       retire,
  output logic [2:0] state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  // The datapath width never reaches a port; only 32 is meaningful.
  if (XLEN != 32) begin : g_xlen_unsupported
  end

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_OTHER,
    C_BR,
    C_LD,
    C_ST,
    C_JAL,
    C_JALR,
    C_ILL
  } cls_t;

  state_t     state, nstate;
  cls_t       d_cls, cls_q;
  logic [1:0] d_alu_op, alu_op_q;
  logic       d_alu_src, alu_src_q;
  logic [2:0] d_imm, imm_q;
  logic [1:0] d_wb, wb_q;
  logic       d_rw, rw_q;

  // Opcode decode; only captured while in DECODE.
  always_comb begin
    d_cls     = C_OTHER;
    d_alu_op  = 2'd0;
    d_alu_src = 1'b0;
    d_imm     = 3'd0;
    d_wb      = 2'd0;
    d_rw      = 1'b0;
    unique case (1'b1)
      (opcode == OP_R): begin
        d_alu_op  = 2'd2;
        d_alu_src = 1'b1;
        d_rw      = 1'b1;
      end
      (opcode == OP_I): begin
        d_alu_op = 2'd2;
        d_imm    = 3'd1;
        d_rw     = 1'b1;
      end
      (opcode == OP_LW): begin
        d_cls = C_LD;
        d_imm = 3'd1;
        d_wb  = 2'd1;
        d_rw  = 1'b1;
      end
      (opcode == OP_SW): begin
        d_cls = C_ST;
        d_imm = 3'd2;
      end
      (opcode == OP_B): begin
        d_cls     = C_BR;
        d_alu_op  = 2'd1;
        d_alu_src = 1'b1;
        d_imm     = 3'd3;
      end
      (opcode == OP_JALR): begin
        d_cls = C_JALR;
        d_imm = 3'd1;
        d_wb  = 2'd2;
        d_rw  = 1'b1;
      end
      (opcode == OP_JAL): begin
        d_cls = C_JAL;
        d_imm = 3'd5;
        d_wb  = 2'd2;
        d_rw  = 1'b1;
      end
      (opcode == OP_AUIPC): begin
        d_imm = 3'd4;
        d_wb  = 2'd3;
        d_rw  = 1'b1;
      end
      (opcode == OP_LUI): begin
        d_alu_op = 2'd3;
        d_imm    = 3'd4;
        d_rw     = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        d_cls = C_ILL;
`else
        d_cls = C_OTHER;
`endif
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= nstate;
  end

  // Latch decoded controls once per instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q     <= C_OTHER;
      alu_op_q  <= 2'd0;
      alu_src_q <= 1'b0;
      imm_q     <= 3'd0;
      wb_q      <= 2'd0;
      rw_q      <= 1'b0;
    end else if (state == S_DECODE) begin
      cls_q     <= d_cls;
      alu_op_q  <= d_alu_op;
      alu_src_q <= d_alu_src;
      imm_q     <= d_imm;
      wb_q      <= d_wb;
      rw_q      <= d_rw;
    end
  end

  // Next state and outputs; everything stays 0 while rst is high.
  always_comb begin
    nstate   = state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    reg_we   = 1'b0;
    wb_sel   = 2'd0;
    alu_op   = 2'd0;
    alu_src  = 1'b0;
    imm_type = 3'd0;
    retire   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal  = 1'b0;
`endif
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we  = 1'b1;
            nstate = S_DECODE;
          end
        end
        S_DECODE: begin
          nstate = (d_cls == C_ILL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          alu_op   = alu_op_q;
          alu_src  = alu_src_q;
          imm_type = imm_q;
          if (cls_q == C_BR) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? 2'd1 : 2'd0;
            retire = 1'b1;
            nstate = S_FETCH;
          end else if (cls_q == C_LD || cls_q == C_ST) begin
            nstate = S_MEM;
          end else begin
            nstate = S_WB;
          end
        end
        S_MEM: begin
          alu_op   = alu_op_q;
          alu_src  = alu_src_q;
          imm_type = imm_q;
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_ST);
          if (dmem_ready) begin
            if (cls_q == C_ST) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nstate = S_FETCH;
            end else begin
              nstate = S_WB;
            end
          end
        end
        S_WB: begin
          alu_op   = alu_op_q;
          alu_src  = alu_src_q;
          imm_type = imm_q;
          reg_we   = rw_q;
          wb_sel   = wb_q;
          pc_we    = 1'b1;
          retire   = 1'b1;
          if (cls_q == C_JAL)       pc_sel = 2'd1;
          else if (cls_q == C_JALR) pc_sel = 2'd2;
          nstate   = S_FETCH;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
          nstate  = S_TRAP;
        end
        default: nstate = S_FETCH;
      endcase
    end
  end

  // Debug view of the current state.
  assign state_o = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for multicycle_ctrl.
// Expected retire records come from an opcode-rule model; a monitor pops them.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
  logic       reg_we, alu_src, retire;
  logic [1:0] pc_sel, wb_sel, alu_op;
  logic [2:0] imm_type, state_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_op(alu_op), .alu_src(alu_src), .imm_type(imm_type),
    .retire(retire), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [2:0] imm;
    logic       dwe;
    logic [7:0] lat;
  } rec_t;

  int   total = 0;
  int   bad = 0;
  int   nret = 0;
  int   iw_cur = 0;
  int   dw_cur = 0;
  rec_t expq[$];

  // Reference: per-opcode rules, latency = base + wait cycles.
  function automatic rec_t model(logic [6:0] op, logic br, int iw, int dw);
    rec_t r;
    int   base;
    logic mem;
    r    = '0;
    base = 4;
    mem  = 1'b0;
    case (op)
      7'b0110011: begin r.reg_we = 1; r.alu_op = 2; r.alu_src = 1; end
      7'b0010011: begin r.reg_we = 1; r.alu_op = 2; r.imm = 1; end
      7'b0000011: begin r.reg_we = 1; r.imm = 1; r.wb_sel = 1;
                        base = 5; mem = 1; end
      7'b0100011: begin r.imm = 2; r.dwe = 1; mem = 1; end
      7'b1100011: begin r.alu_op = 1; r.alu_src = 1; r.imm = 3;
                        r.pc_sel = br ? 2'd1 : 2'd0; base = 3; end
      7'b1100111: begin r.reg_we = 1; r.imm = 1; r.wb_sel = 2;
                        r.pc_sel = 2; end
      7'b1101111: begin r.reg_we = 1; r.imm = 5; r.wb_sel = 2;
                        r.pc_sel = 1; end
      7'b0010111: begin r.reg_we = 1; r.imm = 4; r.wb_sel = 3; end
      7'b0110111: begin r.reg_we = 1; r.imm = 4; r.alu_op = 3; end
      default: ;
    endcase
    r.lat = 8'(base + iw + (mem ? dw : 0));
    return r;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111,
                      7'b0110111};
  endfunction

  // Instruction memory: ready after iw_cur wait cycles; noise when idle.
  initial begin
    int icnt;
    icnt = 0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        imem_ready = (icnt == iw_cur);
        if (imem_ready) icnt = 0;
        else icnt++;
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
        icnt = 0;
      end
    end
  end

  // Data memory: ready after dw_cur wait cycles; noise when idle.
  initial begin
    int dcnt;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        dmem_ready = (dcnt == dw_cur);
        if (dmem_ready) dcnt = 0;
        else dcnt++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dcnt = 0;
      end
    end
  end

  // Monitor: per-cycle invariants plus a retire record per instruction.
  initial begin
    int   cyc;
    logic regs, dwes, prev_ir;
    rec_t act, e;
    cyc = 0; regs = 0; dwes = 0; prev_ir = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cyc = 0; regs = 0; dwes = 0; prev_ir = 0;
        expq.delete();
      end else begin
        cyc++;
        total++;
        if (ir_we !== (imem_req & imem_ready)) begin
          bad++;
          $display("FAIL ir_we: got %b need %b", ir_we,
                   imem_req & imem_ready);
        end
        total++;
        if (pc_we !== retire) begin
          bad++;
          $display("FAIL pc_we_retire: pc_we %b need %b", pc_we, retire);
        end
        if (prev_ir) begin
          total++;
          if (state_o !== 3'd1) begin
            bad++;
            $display("FAIL decode_after_ir: state_o %0d need 1", state_o);
          end
        end
        prev_ir = ir_we;
        if (imem_req) begin
          total++;
          if ({alu_op, alu_src, imm_type} !== 6'd0) begin
            bad++;
            $display("FAIL fetch_alu_zero: got %b need 0",
                     {alu_op, alu_src, imm_type});
          end
        end
        if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
          total++;
          if ({reg_we, pc_we, ir_we, retire} !== 4'd0) begin
            bad++;
            $display("FAIL stall_strobe: got %b need 0",
                     {reg_we, pc_we, ir_we, retire});
          end
        end
        if (reg_we) regs = 1;
        if (dmem_req && dmem_we) dwes = 1;
        if (retire) begin
          act.pc_sel  = pc_sel;
          act.reg_we  = regs;
          act.wb_sel  = wb_sel;
          act.alu_op  = alu_op;
          act.alu_src = alu_src;
          act.imm     = imm_type;
          act.dwe     = dwes;
          act.lat     = 8'(cyc);
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_retire: got retire need none");
          end else begin
            e = expq.pop_front();
            if (act !== e) begin
              bad++;
              $display("FAIL retire_rec: got pcs=%0d rw=%0d wb=%0d op=%0d src=%0d imm=%0d dwe=%0d lat=%0d need pcs=%0d rw=%0d wb=%0d op=%0d src=%0d imm=%0d dwe=%0d lat=%0d",
                       act.pc_sel, act.reg_we, act.wb_sel, act.alu_op,
                       act.alu_src, act.imm, act.dwe, act.lat,
                       e.pc_sel, e.reg_we, e.wb_sel, e.alu_op,
                       e.alu_src, e.imm, e.dwe, e.lat);
            end
          end
          nret++;
          cyc = 0; regs = 0; dwes = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Issue one instruction and wait (bounded) for its retire.
  task automatic run(logic [6:0] op, logic br, int iw, int dw);
    int n0;
    int k;
    opcode   = op;
    br_taken = br;
    iw_cur   = iw;
    dw_cur   = dw;
    expq.push_back(model(op, br, iw, dw));
    n0 = nret;
    k  = 0;
    while (nret == n0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (nret == n0) begin
      total++;
      bad++;
      $display("FAIL retire_timeout: op %b got no retire need one", op);
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] pool [11];
    logic [6:0] op;
    int         k;
    pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111, 7'h00,
             7'h7f};

    repeat (3) begin
      @(negedge clk);
      #3;
      total++;
      if ({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we,
           wb_sel, alu_op, alu_src, imm_type, retire, state_o} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got nonzero need all 0");
      end
    end
    iw_cur = 0;
    @(posedge clk);
    #3 rst = 1'b0;

    run(7'b0010011, 0, 0, 0);
    run(7'b0010011, 0, 3, 0);
    run(7'b0000011, 0, 0, 2);
    run(7'b0100011, 0, 0, 2);
    run(7'b1100011, 1, 0, 0);
    run(7'b1100011, 0, 0, 0);
    run(7'b1100111, 0, 0, 0);
    run(7'b1101111, 0, 0, 0);
    run(7'b0010111, 0, 1, 0);
    run(7'b0110111, 0, 0, 0);
    run(7'b0110011, 0, 2, 0);
`ifndef ILLEGAL_TRAP_EN
    run(7'h00, 0, 0, 0);
`endif

    repeat (60) begin
      op = pool[$urandom_range(0, 10)];
`ifdef ILLEGAL_TRAP_EN
      if (!is_legal(op)) op = 7'b0110011;
`endif
      run(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 3));
    end

    // Reset while a load waits in MEM.
    opcode = 7'b0000011;
    dw_cur = 40;
    iw_cur = 0;
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (!dmem_req && k < 20);
    total++;
    if (!dmem_req) begin
      bad++;
      $display("FAIL mem_reach: dmem_req 0 need 1");
    end
    rst = 1'b1;
    #1;
    total++;
    if ({dmem_req, imem_req, state_o} !== 5'd0) begin
      bad++;
      $display("FAIL reset_in_mem: got %b need 0",
               {dmem_req, imem_req, state_o});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    #3;
    total++;
    if (imem_req !== 1'b1 || state_o !== 3'd0) begin
      bad++;
      $display("FAIL restart_fetch: req %b state %0d need 1 0",
               imem_req, state_o);
    end
    @(posedge clk);
    #1;
    run(7'b0100011, 0, 0, 1);

`ifdef ILLEGAL_TRAP_EN
    opcode = 7'h00;
    iw_cur = 0;
    repeat (6) @(negedge clk);
    #3;
    total++;
    if (illegal !== 1'b1 || state_o !== 3'd5 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL trap: ill %b state %0d req %b need 1 5 0",
               illegal, state_o, imem_req);
    end
    do_reset();
`endif

    repeat (3) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d records need 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim did not end");
    $fatal(1);
  end

endmodule
